// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready handshake bundle for the skid-buffered pipe stage,
//               including hazard controls and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             stall;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    // Upstream/downstream driver side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output stall,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy,
        input  stall_cnt
    );

    // Pipe stage side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  stall,
        input  flush,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy,
        output stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry (main + skid) pipeline register with stall, flush,
//               occupancy report and a saturating blocked-output counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_stage_reg_if.slave  bus
);

    localparam logic [1:0]       S_EMPTY   = 2'd0;
    localparam logic [1:0]       S_ONE     = 2'd1;
    localparam logic [1:0]       S_FULL    = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] m_data_q;
    logic [WIDTH-1:0] m_data_d;
    logic [WIDTH-1:0] s_data_q;
    logic [WIDTH-1:0] s_data_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic drain;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic; flush overrides every transfer in the same cycle
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && !drain) begin
                        state_d = S_FULL;
                    end else if (drain && !accept) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State-decoded outputs; in_ready depends on registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        m_valid = 1'b0;
        s_valid = 1'b0;
        case (state_q)
            S_ONE: begin
                m_valid = 1'b1;
            end
            S_FULL: begin
                m_valid = 1'b1;
                s_valid = 1'b1;
            end
            default: begin
                m_valid = 1'b0;
                s_valid = 1'b0;
            end
        endcase
    end

    assign accept        = bus.in_valid & ~s_valid;
    assign drain         = m_valid & bus.out_ready & ~bus.stall;

    assign bus.in_ready  = ~s_valid;
    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data_q;
    assign bus.occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign bus.stall_cnt = stall_cnt_q;

    // ------------------------------------------------------------------------
    // Payload next-state
    // ------------------------------------------------------------------------
    always_comb begin
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (bus.flush) begin
            m_data_d = FLUSH_VAL;
            s_data_d = FLUSH_VAL;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        m_data_d = bus.in_data;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        m_data_d = bus.in_data;
                    end else if (accept) begin
                        s_data_d = bus.in_data;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        m_data_d = s_data_q;
                    end
                end
                default: begin
                    m_data_d = m_data_q;
                end
            endcase
        end
    end

    // Counter is deliberately untouched by flush; only reset clears it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !drain && !bus.flush && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q    <= FLUSH_VAL;
            s_data_q    <= FLUSH_VAL;
            stall_cnt_q <= '0;
        end else begin
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam logic [31:0] C_FLUSH_A = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) a_if ();
    pipe_stage_reg_if #(.WIDTH(8),  .CNT_W(2))  b_if ();

    pipe_stage_reg #(
        .WIDTH     (32),
        .FLUSH_VAL (C_FLUSH_A),
        .CNT_W     (16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    pipe_stage_reg #(
        .WIDTH     (8),
        .FLUSH_VAL (8'h00),
        .CNT_W     (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic rdy,
                           input logic stl, input logic fl);
        a_if.in_valid  = v;
        a_if.in_data   = d;
        a_if.out_ready = rdy;
        a_if.stall     = stl;
        a_if.flush     = fl;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        b_if.in_valid  = 1'b0;
        b_if.in_data   = 8'h00;
        b_if.out_ready = 1'b0;
        b_if.stall     = 1'b0;
        b_if.flush     = 1'b0;
        #1;

        // Reset state before any clock edge
        check("rst_in_ready",  a_if.in_ready,  1);
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_occ",       a_if.occupancy, 0);
        check("rst_out_data",  a_if.out_data,  C_FLUSH_A);
        check("rst_cnt",       a_if.stall_cnt, 0);

        tick();
        tick();
        rst = 1'b0;

        // Single beat, one-cycle latency, then drain keeps last data
        drive_a(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        check("a5_valid", a_if.out_valid, 1);
        check("a5_data",  a_if.out_data,  32'hA5);
        check("a5_occ",   a_if.occupancy, 1);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("a5_drained_occ",  a_if.occupancy, 0);
        check("a5_drained_data", a_if.out_data,  32'hA5);
        check("a5_cnt",          a_if.stall_cnt, 0);

        // Back-to-back 1,2,3 with downstream blocked after the first beat
        drive_a(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_occ",      a_if.occupancy, 2);
        check("full_in_ready", a_if.in_ready,  0);
        check("full_data",     a_if.out_data,  32'h1);
        drive_a(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_hold_occ",  a_if.occupancy, 2);
        check("full_hold_data", a_if.out_data,  32'h1);
        drive_a(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        tick();
        check("seq_2_data", a_if.out_data,  32'h2);
        check("seq_2_occ",  a_if.occupancy, 1);
        tick();
        check("seq_3_data", a_if.out_data,  32'h3);
        check("seq_3_occ",  a_if.occupancy, 1);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("seq_empty_occ", a_if.occupancy, 0);
        check("seq_cnt",       a_if.stall_cnt, 2);

        // Full throughput stream
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b0);
            tick();
            check("stream_data", a_if.out_data,  32'h100 + i);
            check("stream_occ",  a_if.occupancy, 1);
        end
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("stream_cnt", a_if.stall_cnt, 2);

        // Asynchronous reset mid-cycle, then stall hold in FULL
        #3;
        rst = 1'b1;
        #1;
        check("arst_cnt", a_if.stall_cnt, 0);
        check("arst_data", a_if.out_data, C_FLUSH_A);
        tick();
        rst = 1'b0;
        drive_a(1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 32'h20, 1'b1, 1'b1, 1'b0);
        tick();
        check("stl_fill_occ", a_if.occupancy, 2);
        drive_a(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold_data", a_if.out_data, 32'h10);
        end
        check("stl_cnt",      a_if.stall_cnt, 4);
        check("stl_hold_occ", a_if.occupancy, 2);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("stl_resume_data", a_if.out_data, 32'h20);
        check("stl_resume_occ",  a_if.occupancy, 1);
        tick();
        check("stl_done_occ", a_if.occupancy, 0);
        check("stl_done_cnt", a_if.stall_cnt, 4);

        // Flush from FULL discards the offered beat
        drive_a(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        tick();
        check("fl_occ",      a_if.occupancy, 0);
        check("fl_valid",    a_if.out_valid, 0);
        check("fl_data",     a_if.out_data,  C_FLUSH_A);
        check("fl_in_ready", a_if.in_ready,  1);
        check("fl_cnt",      a_if.stall_cnt, 5);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl_no_7", a_if.out_valid, 0);

        // Flush wins over stall
        drive_a(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("flstl_occ",  a_if.occupancy, 0);
        check("flstl_data", a_if.out_data,  C_FLUSH_A);
        check("flstl_cnt",  a_if.stall_cnt, 5);
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Narrow counter saturation on the second instance
        b_if.in_valid = 1'b1;
        b_if.in_data  = 8'h5A;
        tick();
        b_if.in_valid = 1'b0;
        check("b_valid", b_if.out_valid, 1);
        tick();
        tick();
        check("b_cnt_2", b_if.stall_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("b_cnt_sat", b_if.stall_cnt, 3);
        check("b_data",    b_if.out_data,  8'h5A);
        #3;
        rst = 1'b1;
        #1;
        check("b_arst_valid", b_if.out_valid, 0);
        check("b_arst_cnt",   b_if.stall_cnt, 0);
        check("b_arst_ready", b_if.in_ready,  1);
        check("b_arst_occ",   b_if.occupancy, 0);
        check("b_arst_data",  b_if.out_data,  8'h00);
        tick();
        rst = 1'b0;
        b_if.in_valid = 1'b1;
        b_if.in_data  = 8'h3C;
        tick();
        b_if.in_valid = 1'b0;
        check("b_post_valid", b_if.out_valid, 1);
        check("b_post_data",  b_if.out_data,  8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
